// File: rtl/tb_io_pkg.sv
// Shared definitions for the TramelBlaze read-side I/O peripherals:
// register offsets within a peripheral, default base address and bus width.
package tb_io_pkg;

   localparam int          TB_DATA_W         = 16;
   localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0010;

   typedef enum logic [1:0] {
      REG_LEVEL = 2'd0,
      REG_RISE  = 2'd1,
      REG_FALL  = 2'd2
   } reg_off_e;

   // Absolute PORT_ID of a register given the peripheral base address.
   function automatic logic [15:0] reg_addr(input logic [15:0] base, input reg_off_e off);
      return base + {14'd0, off};
   endfunction

endpackage

// File: rtl/tb_switch_input_port_debounce_channel.sv
// One switch channel: two-flop synchronizer followed by a tick-based
// debouncer. A new level is accepted only after DB_TICKS sample ticks of
// continuous disagreement with the current debounced level.
module debounce_channel #(
   parameter int DB_TICKS = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   input  logic i_tick,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int                CNT_W    = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_TICKS - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             w_mismatch;
   logic             w_accept;

   assign w_mismatch = r_sync2 ^ r_level;
   assign w_accept   = w_mismatch & i_tick & (r_cnt == CNT_LAST);

   // Rise/fall strobes coincide with the edge that updates the level.
   assign o_level = r_level;
   assign o_rise  = w_accept &  r_sync2;
   assign o_fall  = w_accept & ~r_sync2;

   // Synchronize the raw switch and qualify level changes over sample ticks.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so r_sync2 really is one stage behind r_sync1.
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            // Any bounce back to the current level restarts qualification.
            r_cnt <= '0;
         end else if (i_tick) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/tb_switch_input_port.sv
// Switch input port for the TramelBlaze I/O bus. Debounces NUM_SW switches,
// keeps sticky rise/fall event registers, decodes three read registers and
// raises an interrupt whenever a new edge event is recorded.
module tb_switch_input_port
   import tb_io_pkg::*;
#(
   parameter int          NUM_SW     = 8,
   parameter int          TICK_COUNT = 500_000,
   parameter int          DB_TICKS   = 4,
   parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SW-1:0]    sw,
   input  logic [15:0]          port_id,
   input  logic                 read_strobe,
   input  logic                 interrupt_ack,
   output logic [TB_DATA_W-1:0] in_port,
   output logic                 interrupt,
   output logic [NUM_SW-1:0]    db_level
);

   localparam int               TICK_W    = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);

   localparam logic [15:0] ADDR_LEVEL = reg_addr(BASE_ADDR, REG_LEVEL);
   localparam logic [15:0] ADDR_RISE  = reg_addr(BASE_ADDR, REG_RISE);
   localparam logic [15:0] ADDR_FALL  = reg_addr(BASE_ADDR, REG_FALL);

   logic [TICK_W-1:0] r_tick_cnt;
   logic              w_tick;
   logic [NUM_SW-1:0] w_rise_set;
   logic [NUM_SW-1:0] w_fall_set;
   logic [NUM_SW-1:0] r_rise_ev;
   logic [NUM_SW-1:0] r_fall_ev;
   logic              r_interrupt;
   logic              w_hit_level;
   logic              w_hit_rise;
   logic              w_hit_fall;
   logic              w_clr_rise;
   logic              w_clr_fall;
   logic              w_any_set;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   // Free-running sample tick shared by all debounce channels.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
   end

   for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
      debounce_channel #(
         .DB_TICKS (DB_TICKS)
      ) u_ch (
         .i_clk   (clk),
         .i_rst_n (rst),
         .i_sw    (sw[g]),
         .i_tick  (w_tick),
         .o_level (db_level[g]),
         .o_rise  (w_rise_set[g]),
         .o_fall  (w_fall_set[g])
      );
   end

   assign w_hit_level = (port_id == ADDR_LEVEL);
   assign w_hit_rise  = (port_id == ADDR_RISE);
   assign w_hit_fall  = (port_id == ADDR_FALL);
   assign w_clr_rise  = read_strobe & w_hit_rise;
   assign w_clr_fall  = read_strobe & w_hit_fall;
   assign w_any_set   = (|w_rise_set) | (|w_fall_set);

   // Sticky event registers; a new event on a bit survives a simultaneous read-clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rise_ev <= '0;
         r_fall_ev <= '0;
      end else begin
         r_rise_ev <= (r_rise_ev & ~{NUM_SW{w_clr_rise}}) | w_rise_set;
         r_fall_ev <= (r_fall_ev & ~{NUM_SW{w_clr_fall}}) | w_fall_set;
      end
   end

   // Interrupt request: a new event outranks a simultaneous acknowledge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_interrupt <= 1'b0;
      end else if (w_any_set) begin
         r_interrupt <= 1'b1;
      end else if (interrupt_ack) begin
         r_interrupt <= 1'b0;
      end
   end

   assign interrupt = r_interrupt;

   // Read mux: exact PORT_ID match, unused upper bits and unmapped addresses read zero.
   always_comb begin
      // NOTE: assigning a default first means every path drives in_port, so no latch is inferred.
      in_port = '0;
      if (w_hit_level) begin
         in_port[NUM_SW-1:0] = db_level;
      end else if (w_hit_rise) begin
         in_port[NUM_SW-1:0] = r_rise_ev;
      end else if (w_hit_fall) begin
         in_port[NUM_SW-1:0] = r_fall_ev;
      end
   end

endmodule

// File: tb/tb_tb_switch_input_port.sv
// Scoreboard bench for tb_switch_input_port with a short tick (4 clocks) and
// 3-tick debounce. Each processor read pushes its expected response; a
// monitor pops and compares whenever read_strobe is presented.
module tb_tb_switch_input_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sw;
   logic [15:0] port_id;
   logic        read_strobe;
   logic        interrupt_ack;
   logic [15:0] in_port;
   logic        interrupt;
   logic [7:0]  db_level;

   int n_chk = 0;
   int n_err = 0;
   int n_cyc = 0;   // edges since reset release, mirrors the tick phase

   typedef struct {
      string       name;
      logic [15:0] data;
      bit          chk_irq;
      logic        irq;
      bit          chk_lvl;
      logic [7:0]  lvl;
   } exp_t;

   exp_t exp_q[$];

   tb_switch_input_port #(
      .NUM_SW     (8),
      .TICK_COUNT (4),
      .DB_TICKS   (3),
      .BASE_ADDR  (16'h0010)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sw            (sw),
      .port_id       (port_id),
      .read_strobe   (read_strobe),
      .interrupt_ack (interrupt_ack),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .db_level      (db_level)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) n_cyc <= rst ? n_cyc + 1 : 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every presented read is compared against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (read_strobe === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_read: got in_port %h with no expectation queued", in_port);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_data"}, 32'(in_port), 32'(e.data));
            if (e.chk_irq) check({e.name, "_irq"}, 32'(interrupt), 32'(e.irq));
            if (e.chk_lvl) check({e.name, "_lvl"}, 32'(db_level), 32'(e.lvl));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] data,
                     input bit ci = 1'b0, input logic irq = 1'b0,
                     input bit cl = 1'b0, input logic [7:0] lvl = 8'h00);
      exp_t e;
      e.name = name; e.data = data; e.chk_irq = ci; e.irq = irq; e.chk_lvl = cl; e.lvl = lvl;
      exp_q.push_back(e);
      port_id     = addr;
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      port_id     = 16'h0000;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      step();
      interrupt_ack = 1'b0;
   endtask

   task automatic wait_level(input string name, input logic [7:0] target, input int budget);
      int i = 0;
      while (db_level !== target && i < budget) begin
         step();
         i++;
      end
      check(name, 32'(db_level), 32'(target));
   endtask

   // Edge index at which a change driven when n_cyc==k is accepted:
   // sync adds 2 edges, then 3 tick edges (multiples of 4) are needed.
   function automatic int accept_edge(input int k);
      int t1;
      t1 = ((k + 3 + 3) / 4) * 4;
      return t1 + 8;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int acc;
      rst = 1'b0; sw = 8'hFF; port_id = 16'h0000; read_strobe = 1'b0; interrupt_ack = 1'b0;

      // 1: reset state, then all switches high are accepted together
      step(); step();
      rd("reset_state", 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00);
      rst = 1'b1;
      wait_level("t1_level_ff", 8'hFF, 15);
      rd("t1_rise",         16'h0011, 16'h00FF, 1'b1, 1'b1);
      rd("t1_rise_cleared", 16'h0011, 16'h0000);
      rd("t1_fall_empty",   16'h0012, 16'h0000);
      sw = 8'h00;
      wait_level("t1_level_00", 8'h00, 16);
      rd("t1_fall", 16'h0012, 16'h00FF);
      ack();
      rd("t1_irq_acked", 16'h0010, 16'h0000, 1'b1, 1'b0);

      // 2: bounce on sw[0] every 3 cycles is rejected
      for (int i = 0; i < 14; i++) begin
         sw[0] = ~sw[0];
         repeat (3) step();
      end
      repeat (20) step();
      rd("t2_level", 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00);
      rd("t2_rise",  16'h0011, 16'h0000);
      rd("t2_fall",  16'h0012, 16'h0000);

      // 3: clean press and release of sw[2]
      sw[2] = 1'b1;
      wait_level("t3_press", 8'h04, 14);
      rd("t3_level_irq", 16'h0010, 16'h0004, 1'b1, 1'b1);
      ack();
      rd("t3_acked",     16'h0010, 16'h0004, 1'b1, 1'b0);
      rd("t3_rise",      16'h0011, 16'h0004);
      rd("t3_rise_clr",  16'h0011, 16'h0000);
      sw[2] = 1'b0;
      wait_level("t3_release", 8'h00, 14);
      rd("t3_fall",      16'h0012, 16'h0004, 1'b1, 1'b1);
      ack();

      // 4: read-clear of rise_ev on the same edge sw[3] is accepted
      sw[4] = 1'b1;
      wait_level("t4_sw4", 8'h10, 14);
      ack();
      sw[3] = 1'b1;
      k   = n_cyc;
      acc = accept_edge(k);
      while (n_cyc < acc - 1) step();
      rd("t4_collide",    16'h0011, 16'h0010, 1'b1, 1'b0, 1'b1, 8'h10);
      rd("t4_after",      16'h0010, 16'h0018, 1'b1, 1'b1);
      rd("t4_rise_new",   16'h0011, 16'h0008);
      rd("t4_rise_clr",   16'h0011, 16'h0000);
      ack();

      // 5: acknowledge on the same edge a new fall event sets
      sw[3] = 1'b0;
      k   = n_cyc;
      acc = accept_edge(k);
      while (n_cyc < acc - 1) step();
      ack();
      rd("t5_irq_kept",   16'h0010, 16'h0010, 1'b1, 1'b1);
      rd("t5_fall",       16'h0012, 16'h0008);
      ack();
      rd("t5_irq_clr",    16'h0010, 16'h0010, 1'b1, 1'b0);

      // 6: unmapped addresses read zero and clear nothing
      sw[4] = 1'b0;
      wait_level("t6_release", 8'h00, 14);
      rd("t6_addr_13",    16'h0013, 16'h0000);
      rd("t6_addr_00",    16'h0000, 16'h0000);
      rd("t6_addr_112",   16'h0112, 16'h0000);
      rd("t6_fall_kept",  16'h0012, 16'h0010, 1'b1, 1'b1);
      rd("t6_fall_clr",   16'h0012, 16'h0000);
      ack();
      rd("t6_irq_clr",    16'h0010, 16'h0000, 1'b1, 1'b0);

      step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
